// File: rtl/pif_regctl.sv
// ---------------------------------------------------------------------------
// pif_regctl
//
// Register-bus controller between the I2C slave byte interface and the
// flasher's control register file. Each received byte carries a 2-bit tag
// in [7:6] and a 6-bit payload in [5:0]:
//   A_ADDR (2'b01) : load the register pointer with the payload
//   D_ADDR (2'b10) : write the payload to the register at the pointer
//   other tags     : illegal, raise the sticky error flag
// Read-back requests (tx_req) share the single register port with writes.
// When a byte and a read request are both eligible, the byte goes first.
// Events that arrive while the FSM is busy wait in one-deep pending slots.
// A second event into a full slot is dropped and raises err.
//
// Compile-time option:
//   REGCTL_AUTOINC_EN - when defined, the pointer advances (with wrap at
//                       NREGS-1) after every completed write and read.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   rx_valid, rx_data     received byte strobe and byte
//   rx_start              START / repeated START seen by the slave
//   tx_req                slave wants the next read byte
//   tx_data, tx_valid     read byte {2'b00, reg_rdata} and its strobe
//   reg_wr, reg_ack       write request (held until ack) and acceptance
//   reg_rd                one-cycle read strobe
//   reg_addr, reg_wdata   register address and write data
//   reg_rdata             read data, valid the cycle after reg_rd
//   busy                  FSM is not idle
//   err                   sticky error flag, cleared only by rst
// ---------------------------------------------------------------------------
module pif_regctl #(
  parameter int NREGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_start,
  input  logic       tx_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [5:0] reg_addr,
  output logic [5:0] reg_wdata,
  input  logic [5:0] reg_rdata,
  input  logic       reg_ack,
  output logic       busy,
  output logic       err
);

  // Tag values shared with the I2C slave.
  localparam logic [1:0] A_ADDR  = 2'b01;
  localparam logic [1:0] D_ADDR  = 2'b10;
  localparam logic [6:0] NREGS_W = 7'(NREGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    RDCAP = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [5:0] ptr, ptr_n, ptr_adv;
  logic       rx_pend, rx_pend_n;
  logic [7:0] rx_buf, rx_buf_n;
  logic       tx_pend, tx_pend_n;
  logic       tx_pend_vis;
  logic       err_n;
  logic [5:0] reg_addr_n, reg_wdata_n;
  logic [7:0] tx_data_n;
  logic       tx_valid_n;
  logic       rx_avail;
  logic [7:0] rx_byte;

  // Pointer value used after a completed write or read.
`ifdef REGCTL_AUTOINC_EN
  localparam logic [5:0] LAST_REG = 6'(NREGS - 1);
  assign ptr_adv = (ptr == LAST_REG) ? 6'd0 : ptr + 6'd1;
`else
  assign ptr_adv = ptr;
`endif

  // A START cancels any read request still waiting, including one that
  // would otherwise be served in this very cycle.
  assign tx_pend_vis = tx_pend & ~rx_start;

  // A pending byte is older than a live one, so it is served first.
  assign rx_avail = rx_pend | rx_valid;
  assign rx_byte  = rx_pend ? rx_buf : rx_data;

  assign reg_wr = (state == WR);
  assign reg_rd = (state == RD);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 6'd0;
      rx_pend   <= 1'b0;
      rx_buf    <= 8'd0;
      tx_pend   <= 1'b0;
      err       <= 1'b0;
      reg_addr  <= 6'd0;
      reg_wdata <= 6'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      rx_pend   <= rx_pend_n;
      rx_buf    <= rx_buf_n;
      tx_pend   <= tx_pend_n;
      err       <= err_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      tx_data   <= tx_data_n;
      tx_valid  <= tx_valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    rx_pend_n   = rx_pend;
    rx_buf_n    = rx_buf;
    tx_pend_n   = tx_pend_vis;
    err_n       = err;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    tx_data_n   = tx_data;
    tx_valid_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (rx_avail) begin
          // When the pending byte is served and a new one arrives in the
          // same cycle, the new byte simply takes over the slot.
          if (rx_pend && rx_valid) begin
            rx_pend_n = 1'b1;
            rx_buf_n  = rx_data;
          end else begin
            rx_pend_n = 1'b0;
          end

          unique case (rx_byte[7:6])
            A_ADDR: begin
              if ({1'b0, rx_byte[5:0]} < NREGS_W) begin
                ptr_n = rx_byte[5:0];
              end else begin
                err_n = 1'b1;
              end
            end
            D_ADDR: begin
              reg_wdata_n = rx_byte[5:0];
              reg_addr_n  = ptr;
              state_n     = WR;
            end
            default: begin
              err_n = 1'b1;
            end
          endcase

          // The byte wins arbitration; a live read request waits.
          if (tx_req) begin
            if (tx_pend_vis) begin
              err_n = 1'b1;
            end else begin
              tx_pend_n = 1'b1;
            end
          end
        end else if (tx_pend_vis || tx_req) begin
          reg_addr_n = ptr;
          state_n    = RD;
          tx_pend_n  = tx_pend_vis & tx_req;
        end
      end

      WR: begin
        if (reg_ack) begin
          ptr_n   = ptr_adv;
          state_n = IDLE;
        end
      end

      RD: begin
        state_n = RDCAP;
      end

      RDCAP: begin
        tx_data_n  = {2'b00, reg_rdata};
        tx_valid_n = 1'b1;
        ptr_n      = ptr_adv;
        state_n    = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // While busy, new events are parked in their slots or dropped.
    if (state != IDLE) begin
      if (rx_valid) begin
        if (rx_pend) begin
          err_n = 1'b1;
        end else begin
          rx_pend_n = 1'b1;
          rx_buf_n  = rx_data;
        end
      end
      if (tx_req) begin
        if (tx_pend_vis) begin
          err_n = 1'b1;
        end else begin
          tx_pend_n = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pif_regctl.sv
// ---------------------------------------------------------------------------
// tb_pif_regctl
//
// Self-checking bench for pif_regctl. A small register-file responder
// acknowledges writes after a programmable delay and returns read data from
// a fixed table. A transaction-level model (pointer, error flag, expected
// write and read-byte queues) predicts what the controller must produce.
// Honours REGCTL_AUTOINC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pif_regctl;

  localparam int NREGS = 8;
  localparam logic [1:0] T_A = 2'b01;
  localparam logic [1:0] T_D = 2'b10;
`ifdef REGCTL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_start;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       reg_wr;
  logic       reg_rd;
  logic [5:0] reg_addr;
  logic [5:0] reg_wdata;
  logic [5:0] reg_rdata;
  logic       reg_ack;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  // Register-file responder state.
  logic [5:0] rf [64];
  logic [5:0] rd_addr_q;
  int         wr_cnt;
  int         ack_delay;

  // Observed and predicted traffic.
  logic [11:0] wr_log [$];
  logic [11:0] exp_wr [$];
  logic [7:0]  tx_log [$];
  logic [7:0]  exp_tx [$];
  logic [5:0]  ptr_m;
  logic        err_m;

  pif_regctl #(.NREGS(NREGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_start  (rx_start),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Ack arrives after reg_wr has been high for ack_delay full cycles.
  assign reg_ack   = reg_wr && (wr_cnt == ack_delay);
  assign reg_rdata = rf[rd_addr_q];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= 0;
      rd_addr_q <= 6'd0;
    end else begin
      wr_cnt <= (reg_wr && !reg_ack) ? wr_cnt + 1 : 0;
      if (reg_rd) rd_addr_q <= reg_addr;
    end
  end

  always @(negedge clk) begin
    if (reg_wr && reg_ack) wr_log.push_back({reg_addr, reg_wdata});
    if (tx_valid) tx_log.push_back(tx_data);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  task automatic model_rx(input logic [7:0] b);
    if (b[7:6] == T_A) begin
      if (int'(b[5:0]) < NREGS) ptr_m = b[5:0];
      else err_m = 1'b1;
    end else if (b[7:6] == T_D) begin
      exp_wr.push_back({ptr_m, b[5:0]});
      if (AUTOINC) ptr_m = 6'((int'(ptr_m) + 1) % NREGS);
    end else begin
      err_m = 1'b1;
    end
  endtask

  task automatic model_tx();
    exp_tx.push_back({2'b00, rf[ptr_m]});
    if (AUTOINC) ptr_m = 6'((int'(ptr_m) + 1) % NREGS);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m = 6'd0;
    err_m = 1'b0;
    wr_log.delete();
    exp_wr.delete();
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      n_checks++;
      $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cyc);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_data, tx_valid, reg_wr, reg_rd, reg_addr, reg_wdata, busy, err} !== 30'd0)
      $display("[TB] FAIL reset_outputs: got %h, required 0",
               {tx_data, tx_valid, reg_wr, reg_rd, reg_addr, reg_wdata, busy, err});
    else n_pass++;
    rst = 1'b0;
    ptr_m = 6'd0;
    err_m = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || reg_wr !== 1'b0)
      $display("[TB] FAIL reset_idle: got busy=%b reg_wr=%b, required 0 0", busy, reg_wr);
    else n_pass++;
  endtask

  task automatic test_write_basic();
    do_reset();
    ack_delay = 0;
    send_rx({T_A, 6'd2});
    model_rx({T_A, 6'd2});
    send_rx({T_D, 6'd1});
    model_rx({T_D, 6'd1});
    n_checks++;
    if (reg_wr !== 1'b1 || reg_addr !== 6'd2 || reg_wdata !== 6'd1)
      $display("[TB] FAIL write_basic: got wr=%b addr=%0d data=%0d, required 1 2 1",
               reg_wr, reg_addr, reg_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (reg_wr !== 1'b0)
      $display("[TB] FAIL write_pulse: got reg_wr=%b one cycle later, required 0", reg_wr);
    else n_pass++;
    wait_idle();
    pulse_tx();
    model_tx();
    wait_idle();
    n_checks++;
    if (tx_log.size() != 1 || tx_log[0] !== exp_tx[0])
      $display("[TB] FAIL write_ptr_after: got %0d bytes first %h, required 1 byte %h",
               tx_log.size(), tx_log[0], exp_tx[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    ack_delay = 1;
    send_rx({T_A, 6'd7}); model_rx({T_A, 6'd7}); wait_idle();
    send_rx({T_D, 6'd5}); model_rx({T_D, 6'd5}); wait_idle();
    send_rx({T_D, 6'd6}); model_rx({T_D, 6'd6}); wait_idle();
    n_checks++;
    if (wr_log.size() != exp_wr.size())
      $display("[TB] FAIL wrap_count: got %0d writes, required %0d", wr_log.size(), exp_wr.size());
    else n_pass++;
    foreach (exp_wr[i]) begin
      if (i < wr_log.size()) begin
        n_checks++;
        if (wr_log[i] !== exp_wr[i])
          $display("[TB] FAIL wrap_write%0d: got addr %0d data %0d, required addr %0d data %0d",
                   i, wr_log[i][11:6], wr_log[i][5:0], exp_wr[i][11:6], exp_wr[i][5:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bad_cmd();
    do_reset();
    ack_delay = 0;
    send_rx({T_A, 6'd1}); model_rx({T_A, 6'd1});
    send_rx({T_A, 6'd9}); model_rx({T_A, 6'd9});
    n_checks++;
    if (err !== 1'b1 || reg_wr !== 1'b0)
      $display("[TB] FAIL bad_addr: got err=%b reg_wr=%b, required 1 0", err, reg_wr);
    else n_pass++;
    send_rx({T_D, 6'd5}); model_rx({T_D, 6'd5});
    wait_idle();
    n_checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_wr[0])
      $display("[TB] FAIL bad_addr_ptr: got %0d writes first %h, required 1 write %h",
               wr_log.size(), wr_log[0], exp_wr[0]);
    else n_pass++;
    do_reset();
    send_rx(8'h05); model_rx(8'h05);
    send_rx(8'hC5); model_rx(8'hC5);
    wait_idle();
    n_checks++;
    if (err !== err_m || wr_log.size() != 0)
      $display("[TB] FAIL bad_tag: got err=%b writes=%0d, required err=%b writes=0",
               err, wr_log.size(), err_m);
    else n_pass++;
  endtask

  task automatic test_read();
    do_reset();
    send_rx({T_A, 6'd4}); model_rx({T_A, 6'd4});
    wait_idle();
    pulse_tx();
    model_tx();
    n_checks++;
    if (reg_rd !== 1'b1 || reg_addr !== 6'd4)
      $display("[TB] FAIL read_strobe: got reg_rd=%b addr=%0d at n+1, required 1 4", reg_rd, reg_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (reg_rd !== 1'b0 || tx_valid !== 1'b0)
      $display("[TB] FAIL read_gap: got reg_rd=%b tx_valid=%b at n+2, required 0 0", reg_rd, tx_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h2A)
      $display("[TB] FAIL read_data: got tx_valid=%b tx_data=%h at n+3, required 1 2a", tx_valid, tx_data);
    else n_pass++;
    tick();
    n_checks++;
    if (tx_valid !== 1'b0)
      $display("[TB] FAIL read_pulse: got tx_valid=%b at n+4, required 0", tx_valid);
    else n_pass++;
    wait_idle();
    pulse_tx();
    model_tx();
    wait_idle();
    n_checks++;
    if (tx_log.size() != 2 || tx_log[1] !== exp_tx[1])
      $display("[TB] FAIL read_ptr_after: got %0d bytes last %h, required 2 bytes last %h",
               tx_log.size(), tx_log[1], exp_tx[1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ack_delay = 0;
    send_rx({T_A, 6'd0}); model_rx({T_A, 6'd0});
    for (int i = 0; i < 4; i++) begin
      send_rx({T_D, 6'(i * 5 + 3)});
      model_rx({T_D, 6'(i * 5 + 3)});
      n_checks++;
      if (reg_wr !== 1'b1)
        $display("[TB] FAIL b2b_wr%0d: got reg_wr=%b, required 1", i, reg_wr);
      else n_pass++;
      tick();
    end
    wait_idle();
    n_checks++;
    if (wr_log != exp_wr || err !== 1'b0)
      $display("[TB] FAIL b2b_log: got %0d writes err=%b, required %0d writes err=0",
               wr_log.size(), err, exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_pending();
    do_reset();
    ack_delay = 5;
    send_rx({T_A, 6'd1}); model_rx({T_A, 6'd1});
    send_rx({T_D, 6'd10}); model_rx({T_D, 6'd10});
    rx_valid = 1'b1;
    rx_data  = {T_D, 6'd21};
    tx_req   = 1'b1;
    tick();
    rx_valid = 1'b0;
    tx_req   = 1'b0;
    model_rx({T_D, 6'd21});
    model_tx();
    wait_idle();
    n_checks++;
    if (wr_log != exp_wr)
      $display("[TB] FAIL pend_writes: got %0d writes last %h, required %0d last %h",
               wr_log.size(), wr_log[$], exp_wr.size(), exp_wr[$]);
    else n_pass++;
    n_checks++;
    if (tx_log != exp_tx || err !== 1'b0)
      $display("[TB] FAIL pend_read: got %0d bytes err=%b, required %0d bytes %h err=0",
               tx_log.size(), err, exp_tx.size(), exp_tx[0]);
    else n_pass++;

    do_reset();
    send_rx({T_A, 6'd3}); model_rx({T_A, 6'd3});
    send_rx({T_D, 6'd1}); model_rx({T_D, 6'd1});
    send_rx({T_D, 6'd2}); model_rx({T_D, 6'd2});
    send_rx({T_D, 6'd3});
    err_m = 1'b1;
    wait_idle();
    n_checks++;
    if (wr_log != exp_wr || err !== 1'b1)
      $display("[TB] FAIL pend_overflow: got %0d writes err=%b, required %0d writes err=1",
               wr_log.size(), err, exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_rx_start();
    do_reset();
    ack_delay = 5;
    send_rx({T_A, 6'd2}); model_rx({T_A, 6'd2});
    send_rx({T_D, 6'd7}); model_rx({T_D, 6'd7});
    pulse_tx();
    tick();
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    wait_idle();
    n_checks++;
    if (tx_log.size() != 0 || wr_log != exp_wr)
      $display("[TB] FAIL start_clear: got %0d reads %0d writes, required 0 reads %0d writes",
               tx_log.size(), wr_log.size(), exp_wr.size());
    else n_pass++;
    ack_delay = 0;
    pulse_tx();
    model_tx();
    wait_idle();
    n_checks++;
    if (tx_log.size() != 1 || tx_log[0] !== exp_tx[0])
      $display("[TB] FAIL start_ptr: got %0d bytes first %h, required 1 byte %h",
               tx_log.size(), tx_log[0], exp_tx[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    logic [7:0] b;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      ack_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      if (r < 8) begin
        b = {T_A, (r == 7) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, NREGS - 1))};
        send_rx(b); model_rx(b);
      end else if (r < 15) begin
        b = {T_D, 6'($urandom_range(0, 63))};
        send_rx(b); model_rx(b);
      end else if (r < 19) begin
        pulse_tx(); model_tx();
      end else begin
        b = {($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 6'($urandom_range(0, 63))};
        send_rx(b); model_rx(b);
      end
      wait_idle();
    end
    n_checks++;
    if (wr_log.size() != exp_wr.size() || tx_log.size() != exp_tx.size())
      $display("[TB] FAIL rand_count: got %0d writes %0d reads, required %0d writes %0d reads",
               wr_log.size(), tx_log.size(), exp_wr.size(), exp_tx.size());
    else n_pass++;
    foreach (exp_wr[i]) begin
      if (i < wr_log.size()) begin
        n_checks++;
        if (wr_log[i] !== exp_wr[i])
          $display("[TB] FAIL rand_write%0d: got %h, required %h", i, wr_log[i], exp_wr[i]);
        else n_pass++;
      end
    end
    foreach (exp_tx[i]) begin
      if (i < tx_log.size()) begin
        n_checks++;
        if (tx_log[i] !== exp_tx[i])
          $display("[TB] FAIL rand_read%0d: got %h, required %h", i, tx_log[i], exp_tx[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (err !== err_m)
      $display("[TB] FAIL rand_err: got %b, required %b", err, err_m);
    else n_pass++;
  endtask

  task automatic test_reset_mid_rd();
    do_reset();
    send_rx({T_A, 6'd5});
    wait_idle();
    pulse_tx();
    n_checks++;
    if (reg_rd !== 1'b1)
      $display("[TB] FAIL midrd_enter: got reg_rd=%b, required 1", reg_rd);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({tx_data, tx_valid, reg_wr, reg_rd, reg_addr, reg_wdata, busy, err} !== 30'd0)
      $display("[TB] FAIL midrd_async: got %h, required 0",
               {tx_data, tx_valid, reg_wr, reg_rd, reg_addr, reg_wdata, busy, err});
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 6'd0;
    err_m = 1'b0;
    exp_tx.delete();
    repeat (5) tick();
    n_checks++;
    if (tx_log.size() != 0)
      $display("[TB] FAIL midrd_no_tx: got %0d tx_valid pulses, required 0", tx_log.size());
    else n_pass++;
    pulse_tx();
    model_tx();
    wait_idle();
    n_checks++;
    if (tx_log.size() != 1 || tx_log[0] !== exp_tx[0])
      $display("[TB] FAIL midrd_ptr: got %0d bytes first %h, required 1 byte %h",
               tx_log.size(), tx_log[0], exp_tx[0]);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'd0;
    rx_start  = 1'b0;
    tx_req    = 1'b0;
    ack_delay = 0;
    ptr_m     = 6'd0;
    err_m     = 1'b0;
    for (int i = 0; i < 64; i++) rf[i] = 6'((i * 37 + 11) % 64);
    rf[4] = 6'h2A;

    $display("[TB] starting pif_regctl bench, autoinc=%0d", AUTOINC);
    test_reset();
    test_write_basic();
    test_wrap();
    test_bad_cmd();
    test_read();
    test_back_to_back();
    test_pending();
    test_rx_start();
    test_random();
    test_reset_mid_rd();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
